// File: rtl/prog_clk_pkg.sv
// Shared types and helpers for the programmable clock generator.
// State encodings stay plain 2-bit constants so legacy tooling can decode them.
package prog_clk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_STOP = 2'd2;

  // Width-independent legality rule: period >= 2 and 1 <= high < period.
  function automatic logic cfg_legal(input logic [31:0] period,
                                     input logic [31:0] high);
    return (period >= 32'd2) && (high >= 32'd1) && (high < period);
  endfunction

endpackage

// File: rtl/prog_clk_gen_cfg_shadow.sv
// Config port: valid/ready handshake, legality check, shadow and active registers.
// The active pair only changes when the generator raises apply at a safe boundary.
module clk_cfg_shadow
  import prog_clk_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 6
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             apply,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             pending,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high
);

  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] shadow_high;
  logic             accept;
  logic             legal;

  // A single-entry shadow: the port stays closed until the held config is applied.
  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = cfg_legal(32'(cfg_period), 32'(cfg_high));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      act_period    <= CNT_W'(DEF_PERIOD);
      act_high      <= CNT_W'(DEF_HIGH);
      shadow_period <= '0;
      shadow_high   <= '0;
      pending       <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= accept & ~legal;
      // accept requires !pending, so it can never collide with an apply.
      if (apply && pending) begin
        act_period <= shadow_period;
        act_high   <= shadow_high;
        pending    <= 1'b0;
      end
      if (accept && legal) begin
        shadow_period <= cfg_period;
        shadow_high   <= cfg_high;
        pending       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_clk_gen.sv
// Runtime-programmable divided clock / tick generator with graceful stop
// and boundary-aligned config updates.
module prog_clk_gen
  import prog_clk_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 6
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  state_t           state;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] cnt_next;
  logic             pending;
  logic             wrap;
  logic             apply;

  assign busy     = (state != ST_IDLE);
  assign wrap     = busy && (cnt == act_period - CNT_W'(1));
  assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);
  // New values land only where a fresh period begins, so no pulse is ever cut.
  assign apply    = pending && ((state == ST_IDLE) || wrap);

  clk_cfg_shadow #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_shadow (
    .clk_in     (clk_in),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .apply      (apply),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .pending    (pending),
    .act_period (act_period),
    .act_high   (act_high)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          clk_out <= en;
          tick    <= en;
          if (en) state <= ST_RUN;
        end
        ST_RUN, ST_STOP: begin
          if (wrap && !en) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
          end else begin
            // Re-asserting en while stopping simply resumes without a gap.
            state   <= en ? ST_RUN : ST_STOP;
            cnt     <= cnt_next;
            clk_out <= (cnt_next < act_high);
            tick    <= (cnt_next == '0);
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_clk_gen.sv
// Self-checking bench for prog_clk_gen against a period/phase reference model.
module tb_prog_clk_gen;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_high = '0;
  logic       cfg_ready, cfg_err, clk_out, tick, busy;
  logic [7:0] cnt;
  logic [12:0] obs;

  int errors = 0;
  int checks = 0;

  typedef struct {int p; int h;} cfg_t;
  cfg_t pend[$];
  bit   m_run, m_err;
  int   m_phase, m_p, m_h;

  prog_clk_gen #(.CNT_W(8), .DEF_PERIOD(10), .DEF_HIGH(6)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy),
    .cnt        (cnt)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {cfg_ready, cfg_err, clk_out, tick, busy, cnt};

  // Expected outputs follow directly from position within the period.
  function automatic logic [12:0] exp_vec();
    logic [7:0] c;
    c = m_run ? 8'(m_phase) : 8'd0;
    return {pend.size() == 0, m_err, m_run && (m_phase < m_h),
            m_run && (m_phase == 0), m_run, c};
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_phase = 0; m_p = 10; m_h = 6;
    pend.delete();
  endtask

  task automatic model_apply();
    cfg_t c;
    if (pend.size() != 0) begin
      c = pend.pop_front();
      m_p = c.p; m_h = c.h;
    end
  endtask

  // One clock edge: a running generator continues at each period end iff en is high.
  task automatic model_edge(input bit e, input bit v, input int p, input int h);
    bit acc, legal;
    acc   = v && (pend.size() == 0);
    legal = (p >= 2) && (h >= 1) && (h < p);
    m_err = acc && !legal;
    if (m_run) begin
      if (m_phase == m_p - 1) begin
        model_apply();
        m_phase = 0;
        if (!e) m_run = 0;
      end else m_phase++;
    end else begin
      model_apply();
      m_phase = 0;
      if (e) m_run = 1;
    end
    if (acc && legal) pend.push_back(cfg_t'{p, h});
  endtask

  task automatic step(input bit e, input bit v, input int p, input int h);
    en = e; cfg_valid = v; cfg_period = p[7:0]; cfg_high = h[7:0];
    @(posedge clk_in);
    model_edge(e, v, p, h);
    #1;
  endtask

  task automatic do_reset();
    en = 0; cfg_valid = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 reset = 1;
  endtask

  task automatic run_to(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_run && m_phase == target) begin ok = 1; break; end
      step(1, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    model_reset();
    #12;
    checks++;
    if (obs !== 13'h1000) begin
      errors++; $display("FAIL reset_values: got %h expected %h", obs, 13'h1000);
    end
    @(posedge clk_in); #1 reset = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL idle cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_defaults();
    int highs = 0, ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL defaults cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i < 10) begin highs += int'(clk_out); ticks += int'(tick); end
    end
    checks++;
    if (highs != 6 || ticks != 1) begin
      errors++; $display("FAIL default_duty: got high=%0d ticks=%0d expected high=6 ticks=1", highs, ticks);
    end
  endtask

  task automatic test_reprogram();
    bit ok;
    run_to(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reprog_timeout: got no cnt=3 expected cnt=3"); end
    step(1, 1, 4, 1);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL reprog_ready: got %b expected 0", cfg_ready);
    end
    for (int i = 0; i < 25; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reprog cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_illegal();
    int ip[3] = '{5, 1, 8};
    int ih[3] = '{5, 0, 0};
    for (int k = 0; k < 3; k++) begin
      step(1, 1, ip[k], ih[k]);
      checks++;
      if (cfg_err !== 1'b1 || obs !== exp_vec()) begin
        errors++; $display("FAIL illegal_%0d: got %h expected %h", k, obs, exp_vec());
      end
      step(1, 0, 0, 0);
      checks++;
      if (cfg_err !== 1'b0 || obs !== exp_vec()) begin
        errors++; $display("FAIL illegal_after_%0d: got %h expected %h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    bit ok;
    do_reset();
    run_to(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stop_timeout: got no cnt=2 expected cnt=2"); end
    for (int i = 0; i < 20 && m_run; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL stop cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b0 || clk_out !== 1'b0) begin
      errors++; $display("FAIL stop_idle: got busy=%b clk_out=%b expected 0 0", busy, clk_out);
    end
    run_to(5, ok);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL resume cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL resume_busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_reset_pending();
    bit ok;
    int highs = 0;
    do_reset();
    run_to(1, ok);
    step(1, 1, 3, 2);
    run_to(4, ok);
    checks++;
    if (!ok || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rstpend_setup: got ready=%b expected 0", cfg_ready);
    end
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== 13'h1000) begin
      errors++; $display("FAIL rstpend_values: got %h expected %h", obs, 13'h1000);
    end
    @(posedge clk_in); #1 reset = 1;
    for (int i = 0; i < 22; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rstpend cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i < 10) highs += int'(clk_out);
    end
    checks++;
    if (highs != 6) begin
      errors++; $display("FAIL rstpend_duty: got high=%0d expected 6", highs);
    end
  endtask

  task automatic test_fast();
    int toggles = 0;
    logic prev;
    do_reset();
    step(0, 1, 2, 1);
    step(0, 0, 0, 0);
    checks++;
    if (obs !== exp_vec() || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL fast_load: got %h expected %h", obs, exp_vec());
    end
    prev = clk_out;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (obs !== exp_vec() || tick !== clk_out) begin
        errors++; $display("FAIL fast cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (clk_out != prev) toggles++;
      prev = clk_out;
    end
    checks++;
    if (toggles != 10) begin
      errors++; $display("FAIL fast_toggle: got %0d toggles expected 10", toggles);
    end
  endtask

  task automatic test_random();
    bit e, v;
    int p, h;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 3) == 0);
      p = $urandom_range(0, 12);
      h = $urandom_range(0, 12);
      step(e, v, p, h);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reprogram();
    test_illegal();
    test_stop();
    test_reset_pending();
    test_fast();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_clk_gen.md
Name: prog_clk_gen

Overview:
- Runtime-programmable clock-enable/divided-clock generator. Successor to the fixed-parameter divider.
- Produces a registered divided output `clk_out` from `clk_in`. Period and high time are parametrised in width, with reset defaults, and reprogrammable at runtime through a valid/ready config port.
- New config values are applied glitch-free at the period boundary. Enable/disable is graceful, and illegal configs are reported.
- Sits beside the top-level clock source and feeds peripheral timing (baud ticks, PWM-like strobes).

Parameters:
- CNT_W, 8, width of the period/high/count fields.
- DEF_PERIOD, 10, period in clk_in cycles after reset (must be ≥2 and < 2^CNT_W).
- DEF_HIGH, 6, high cycles per period after reset (1..DEF_PERIOD-1).

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run request.
- cfg_valid  in  1  config offer.
- cfg_period  in  CNT_W  requested period.
- cfg_high  in  CNT_W  requested high count.
- cfg_ready  out  1  config port can accept.
- cfg_err  out  1  one-cycle pulse: offered config rejected.
- clk_out  out  1  generated divided clock (registered).
- tick  out  1  one-cycle pulse on the first cycle of each period.
- busy  out  1  generator running.
- cnt  out  CNT_W  current position in period.

Behaviour:
- Reset (async assert, sync release) sets:
  - clk_out=0, tick=0, busy=0, cnt=0, cfg_ready=1, cfg_err=0;
  - active period/high = DEF_PERIOD/DEF_HIGH;
  - shadow empty (pending=0).
- State machine, three states: IDLE, RUN, STOP.
  - IDLE: cnt=0, clk_out=0. When en=1, go to RUN.
  - RUN, first cycle: cnt=0, clk_out=1, tick=1. So the first output rise is one clk_in edge after en is sampled high.
  - RUN, each edge: cnt <= (cnt==P-1) ? 0 : cnt+1; clk_out <= (next cnt < H); tick <= (next cnt==0).
  - Result: clk_out is high for exactly H cycles and low for P-H cycles, with no glitches. P and H are the active values.
  - RUN with en=0: go to STOP. Counting continues unchanged until the current period completes (cnt==P-1 edge), then go to IDLE. No truncated high pulse.
  - STOP with en=1 again: cancel the stop and stay in RUN seamlessly.
  - busy=1 in RUN and STOP.
- Config handshake:
  - A config is transferred on a clk_in edge with cfg_valid & cfg_ready.
  - Legal iff cfg_period ≥ 2 and 1 ≤ cfg_high < cfg_period.
  - Illegal: cfg_err=1 for one cycle next edge; shadow and active values untouched; cfg_ready stays 1.
  - Legal: load shadow, set pending=1, cfg_ready=0.
- Config apply:
  - In IDLE, pending values become active on the next edge.
  - In RUN/STOP, they become active on the wrap edge (cnt==P-1→0), so the new period starts at cnt=0 with the new values.
  - On apply: pending=0, cfg_ready=1 on the same edge.
- Simultaneous events:
  - Accept and wrap on the same edge: the new config is not applied until the following wrap.
  - en=0 and pending apply at the same wrap: apply still happens, then go to IDLE.
- Reset mid-operation: immediate return to reset values; any pending config is discarded.
- Width rule: all compares are unsigned CNT_W-bit. cnt never exceeds P-1.

Decomposition:
- Package prog_clk_pkg holds:
  - state enum {IDLE, RUN, STOP};
  - a helper constant/function for config legality.
- Natural sub-module clk_cfg_shadow contains the handshake, legality check, shadow/active registers and apply strobe input. The top level contains the FSM and counter.

Test Plan:
1. Reset, en=1 with defaults P=10, H=6 → clk_out 6 high / 4 low, repeating; tick every 10 cycles; first rise one edge after en.
2. While running, offer P=4, H=1 at cnt=3 → cfg_ready drops; the current 10-cycle period completes; then 1 high / 3 low; cfg_ready returns at the wrap.
3. Offer illegal configs (P=5, H=5), (P=1, H=0), (P=8, H=0) → cfg_err pulses once each; output timing unchanged.
4. Drop en at cnt=2 → clk_out finishes its 6-high/4-low period, then IDLE with clk_out=0, busy=0. Re-assert en during STOP → no gap, next period starts normally.
5. Assert reset at cnt=4 with a config pending → all outputs go to reset values immediately; after release, defaults P=10, H=6 apply, not the pending config.
6. In IDLE, load P=2, H=1, then en=1 → clk_out toggles every cycle (50% duty); tick on every high cycle.
